// File: rtl/fx_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : fx_i2s_tx
// Purpose  : Stereo I2S transmitter at the end of the FX chain. Parallel
//            stereo samples arriving with a sample_en strobe are buffered in a
//            one-deep holding register and serialized MSB first as
//            bclk/lrclk/sdata in standard I2S framing (data delayed one bclk
//            after each lrclk edge). Sticky flags report rate mismatch.
// Ports    : clk         - system clock
//            reset       - asynchronous, active-high reset
//            audio_in    - stereo sample, [0]=left, [1]=right
//            sample_en   - one-cycle strobe, audio_in valid
//            status_clr  - clears underrun/overrun (a same-cycle set wins)
//            i2s_bclk    - bit clock
//            i2s_lrclk   - word select, 0=left slot, 1=right slot
//            i2s_sdata   - serial data, MSB first
//            frame_start - one-clk pulse when a frame enters the shifter
//            underrun    - sticky, frame loaded with no new sample pending
//            overrun     - sticky, pending sample overwritten before sending
// Revision : 1.0 - initial release
// ============================================================================
module fx_i2s_tx #(
   parameter int DATA_W   = 16,
   parameter int SLOT_W   = 32,
   parameter int BCLK_DIV = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0][DATA_W-1:0] audio_in,
   input  logic                   sample_en,
   input  logic                   status_clr,
   output logic                   i2s_bclk,
   output logic                   i2s_lrclk,
   output logic                   i2s_sdata,
   output logic                   frame_start,
   output logic                   underrun,
   output logic                   overrun
);

   localparam int c_frame_w = 2 * SLOT_W;
   localparam int c_pad_w   = SLOT_W - DATA_W;
   localparam int c_div_w   = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int c_bit_w   = (c_frame_w > 2) ? $clog2(c_frame_w) : 1;

   localparam logic [c_div_w-1:0] c_div_max = c_div_w'(BCLK_DIV - 1);
   localparam logic [c_bit_w-1:0] c_bit_max = c_bit_w'(c_frame_w - 1);
   localparam logic [c_bit_w-1:0] c_slot    = c_bit_w'(SLOT_W);

   logic [c_div_w-1:0]        r_div;
   logic                      r_bclk;
   logic                      r_lrclk;
   logic                      r_sdata;
   logic                      r_fs;
   logic                      r_under;
   logic                      r_over;
   logic [1:0][DATA_W-1:0]    r_hold;
   logic                      r_pend;
   logic                      r_first;
   logic [c_bit_w-1:0]        r_bit;
   logic [c_frame_w-1:0]      r_shift;

   logic                      w_wrap;
   logic                      w_fall;
   logic [c_bit_w-1:0]        w_bit_nxt;
   logic                      w_load;
   logic [1:0][DATA_W-1:0]    w_src;
   logic [c_frame_w-1:0]      w_frame;
   logic                      w_under_set;
   logic                      w_over_set;

   assign w_wrap    = (r_div == c_div_max);
   // Only the 1->0 bclk transition advances the serial state.
   assign w_fall    = w_wrap & r_bclk;
   assign w_bit_nxt = (r_bit == c_bit_max) ? '0 : r_bit + 1'b1;
   assign w_load    = w_fall & (w_bit_nxt == '0);

   // A strobe coinciding with the load goes straight into the frame.
   assign w_src     = sample_en ? audio_in : r_hold;

   // The very first load after reset has nothing meaningful to compare
   // against, so it never counts as an underrun.
   assign w_under_set = w_load & ~sample_en & ~r_pend & ~r_first;
   assign w_over_set  = sample_en & ~w_load & r_pend;

   // Each sample is left-justified in its slot; zero padding only exists
   // when the slot is wider than the sample.
   generate
      if (c_pad_w > 0) begin : g_pad
         assign w_frame = {w_src[0], {c_pad_w{1'b0}}, w_src[1], {c_pad_w{1'b0}}};
      end else begin : g_nopad
         assign w_frame = {w_src[0], w_src[1]};
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_div   <= '0;
         r_bclk  <= 1'b0;
         r_lrclk <= 1'b1;
         r_sdata <= 1'b0;
         r_fs    <= 1'b0;
         r_under <= 1'b0;
         r_over  <= 1'b0;
         r_hold  <= '0;
         r_pend  <= 1'b0;
         r_first <= 1'b1;
         r_bit   <= c_bit_max;
         r_shift <= '0;
      end else begin
         r_div <= w_wrap ? '0 : r_div + 1'b1;
         if (w_wrap) begin
            r_bclk <= ~r_bclk;
         end

         r_fs <= w_load;

         if (w_fall) begin
            r_bit   <= w_bit_nxt;
            r_lrclk <= (w_bit_nxt >= c_slot);
            // On a load tick this still emits the last bit of the old frame,
            // which gives the one-bclk I2S data delay after lrclk.
            r_sdata <= r_shift[c_frame_w-1];
            r_shift <= w_load ? w_frame : {r_shift[c_frame_w-2:0], 1'b0};
         end

         // Holding register only captures strobes outside the load cycle;
         // a bypassed sample is sent but not retained.
         if (w_load) begin
            r_pend  <= 1'b0;
            r_first <= 1'b0;
         end else if (sample_en) begin
            r_hold <= audio_in;
            r_pend <= 1'b1;
         end

         if (w_under_set) begin
            r_under <= 1'b1;
         end else if (status_clr) begin
            r_under <= 1'b0;
         end

         if (w_over_set) begin
            r_over <= 1'b1;
         end else if (status_clr) begin
            r_over <= 1'b0;
         end
      end
   end

   assign i2s_bclk    = r_bclk;
   assign i2s_lrclk   = r_lrclk;
   assign i2s_sdata   = r_sdata;
   assign frame_start = r_fs;
   assign underrun    = r_under;
   assign overrun     = r_over;

endmodule
`default_nettype wire

// File: doc/fx_i2s_tx.md
Name: fx_i2s_tx

Overview:
- Stereo I2S transmitter at the output end of the FX chain.
- Accepts parallel stereo samples on the same interface the FX blocks drive (audio pair plus sample_en strobe) and serializes them to the DAC as bclk/lrclk/sdata in standard I2S format.
- One-deep holding buffer decouples the sample_en rate from the frame rate; sticky flags report rate mismatch.

Parameters:
- DATA_W, 16, sample width per channel, two's complement; must be ≤ SLOT_W.
- SLOT_W, 32, bclk periods per channel slot; frame = 2*SLOT_W bits.
- BCLK_DIV, 4, clk cycles per bclk half-period (≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- audio_in  in  [1:0][DATA_W-1:0]  stereo sample; [0]=left, [1]=right.
- sample_en  in  1  one-cycle strobe; audio_in is valid this cycle.
- status_clr  in  1  clears the sticky flags.
- i2s_bclk  out  1  bit clock.
- i2s_lrclk  out  1  word select; 0 = left slot, 1 = right slot.
- i2s_sdata  out  1  serial data, MSB first.
- frame_start  out  1  one-clk pulse when a frame is loaded into the shifter.
- underrun  out  1  sticky: a frame was loaded with no new sample pending.
- overrun  out  1  sticky: a new sample overwrote an unsent pending sample.

Behaviour:
- Reset (async) values: i2s_bclk=0, i2s_lrclk=1, i2s_sdata=0, frame_start=0, underrun=0, overrun=0, holding regs=0, pending=0, div_cnt=0, bit_cnt=2*SLOT_W-1, shifter=0.
- Divider: div_cnt counts 0..BCLK_DIV-1 and wraps. On a wrap, i2s_bclk toggles. A 1→0 toggle is a "falling tick"; all data/lrclk updates occur only on falling ticks, registered.
- Falling tick:
  - bit_cnt ← (bit_cnt+1) mod 2*SLOT_W.
  - i2s_lrclk ← (new bit_cnt ≥ SLOT_W).
  - i2s_sdata ← shifter MSB.
  - Shifter shifts left one bit, filling 0.
- Frame word: {L, (SLOT_W-DATA_W) zeros, R, (SLOT_W-DATA_W) zeros}.
- Frame load: on the falling tick where new bit_cnt=0, the shifter loads the frame word and frame_start pulses for that one clk. The sdata driven on that same tick is the last bit of the previous frame.
- Resulting I2S alignment: each slot's MSB appears one bclk after the lrclk transition.
- Load source:
  - sample_en in the load cycle: audio_in is used directly (bypass); pending ← 0.
  - Else pending=1: holding regs are used; pending ← 0.
  - Else: holding regs are re-sent and underrun ← 1. Exception: the first load after reset never flags underrun.
- sample_en outside a load cycle: holding ← audio_in, pending ← 1. If pending was already 1, overrun ← 1 (newest sample wins).
- status_clr clears underrun/overrun. If a set event occurs in the same cycle, the set wins.
- Timing (defaults):
  - bclk period = 2*BCLK_DIV = 8 clk.
  - Frame = 2*SLOT_W bclk = 512 clk.
  - First falling tick, and therefore first load, occurs 2*BCLK_DIV clk after reset deassertion.
- Latency: a sample accepted at cycle t is sent in the frame loaded at the first load at or after t. Its left MSB appears on sdata one falling tick after that load.
- Reset mid-frame: all outputs return to reset values immediately. The partial frame is abandoned; on release, timing restarts as from power-up.
- Width rules: no arithmetic on samples; bits are transmitted verbatim. DATA_W=SLOT_W means no padding.

Test Plan:
- Reset, then one sample_en with L=16'hA5F0, R=16'h0F0F before the first load. Expect frame_start 8 clk after release; sdata over the next 64 bclk falling edges is the bit stream 1010_0101_1111_0000, 16 zeros, 0000_1111_0000_1111, 16 zeros; lrclk 0 for 32 bclk, then 1. underrun stays 0.
- No sample_en for two frames after the first. Second and third frames repeat A5F0/0F0F; underrun=1 after the second load; status_clr → 0.
- Two sample_en strobes (1111, then 2222 on both channels) within one frame. overrun=1; the next frame carries 2222.
- sample_en with 16'h7FFF/16'h8000 asserted exactly in the load cycle. That frame carries the new values (bypass), underrun stays 0.
- Assert reset at bit_cnt=20 of a frame. Outputs immediately go to bclk=0, lrclk=1, sdata=0, flags 0; after release, the first frame_start occurs again 8 clk later.
- BCLK_DIV=1, SLOT_W=16, DATA_W=16. bclk period 2 clk, frame 64 clk; the 16-bit samples fill the slots with no padding.
